// File: rtl/bank_arb_pkg.sv
// Shared types and default sizing for the bank-group arbiter and its picker.
package bank_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_GROUPS = 4;
    localparam int DEF_MAX_BURSTS = 4;
    localparam int DEF_TIMEOUT    = 16;
    localparam int DEF_CREDITS    = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requesting group at or after ptr, wrapping.
module rr_picker
    import bank_arb_pkg::*;
#(
    parameter int NUM_GROUPS = DEF_NUM_GROUPS
) (
    input  logic [NUM_GROUPS-1:0]         req,
    input  logic [$clog2(NUM_GROUPS)-1:0] ptr,
    output logic [$clog2(NUM_GROUPS)-1:0] gnt_idx,
    output logic                          gnt_vld
);

    localparam int IDX_W = $clog2(NUM_GROUPS);

    always_comb begin : pick
        logic [IDX_W-1:0] idx;
        // NOTE: every output gets a default before the loop, otherwise the no-request path infers a latch.
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_GROUPS);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/bank_group_arbiter.sv
// Grants one bank group at a time to drain bursts into a credit-limited downstream buffer,
// rotating on burst count, timeout or request drop, and parking in IDLE when credits run out.
module bank_group_arbiter
    import bank_arb_pkg::*;
#(
    parameter int NUM_GROUPS = DEF_NUM_GROUPS,
    parameter int MAX_BURSTS = DEF_MAX_BURSTS,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CREDITS    = DEF_CREDITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_GROUPS-1:0]          req,
    input  logic [NUM_GROUPS-1:0]          done,
    input  logic                           pop,
    output logic [NUM_GROUPS-1:0]          start,
    output logic                           wr_en,
    output logic [$clog2(NUM_GROUPS)-1:0]  sel,
    output logic [$clog2(CREDITS+1)-1:0]   credit_cnt
);

    localparam int IDX_W = $clog2(NUM_GROUPS);
    localparam int CRD_W = $clog2(CREDITS + 1);
    localparam int BST_W = $clog2(MAX_BURSTS + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grp_q, grp_d;
    logic [BST_W-1:0] burst_q, burst_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CRD_W-1:0] credit_q, credit_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             done_hit;
    logic [IDX_W-1:0] grp_next;

    rr_picker #(
        .NUM_GROUPS (NUM_GROUPS)
    ) u_rr_picker (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grp_d    = grp_q;
        burst_d  = burst_q;
        timer_d  = timer_q;
        credit_d = credit_q;
        done_hit = (state_q == ST_GRANT) && done[grp_q];
        grp_next = (grp_q == IDX_W'(NUM_GROUPS - 1)) ? '0 : grp_q + 1'b1;

        // A pop and a counted done together cancel out; each direction saturates alone.
        if (pop && !done_hit) begin
            if (credit_q != CRD_W'(CREDITS)) credit_d = credit_q + 1'b1;
        end else if (done_hit && !pop) begin
            if (credit_q != '0) credit_d = credit_q - 1'b1;
        end

        case (state_q)
            ST_GRANT: begin
                timer_d = timer_q + 1'b1;
                burst_d = burst_q + BST_W'(done_hit);
                if (credit_d == '0) begin
                    state_d = ST_IDLE;
                    ptr_d   = grp_next;
                end else if (!req[grp_q] || burst_d == BST_W'(MAX_BURSTS) ||
                             timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = ST_SWITCH;
                    ptr_d   = grp_next;
                end
            end
            default: begin
                // SWITCH is the one-cycle bubble; from here on it arbitrates exactly like IDLE.
                state_d = ST_IDLE;
                if (pick_vld && credit_q != '0) begin
                    state_d = ST_GRANT;
                    grp_d   = pick_idx;
                    burst_d = '0;
                    timer_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grp_q    <= '0;
            burst_q  <= '0;
            timer_q  <= '0;
            credit_q <= CRD_W'(CREDITS);
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grp_q    <= grp_d;
            burst_q  <= burst_d;
            timer_q  <= timer_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        start = '0;
        wr_en = 1'b0;
        sel   = '0;
        if (state_q == ST_GRANT) begin
            start[grp_q] = 1'b1;
            wr_en        = 1'b1;
            sel          = grp_q;
        end
    end

    assign credit_cnt = credit_q;

endmodule

// File: tb/tb_bank_group_arbiter.sv
// Directed checks of grant order, rotation triggers, credit accounting and reset abort.
module tb_bank_group_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic       pop;
    logic [3:0] start;
    logic       wr_en;
    logic [1:0] sel;
    logic [3:0] credit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bank_group_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .pop        (pop),
        .start      (start),
        .wr_en      (wr_en),
        .sel        (sel),
        .credit_cnt (credit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int g);
        check({tag, "_start"}, start, 32'(1 << g));
        check({tag, "_sel"},   sel,   32'(g));
        check({tag, "_wr_en"}, wr_en, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_start"}, start, 0);
        check({tag, "_sel"},   sel,   0);
        check({tag, "_wr_en"}, wr_en, 0);
    endtask

    initial begin
        rst = 1'b1; req = '0; done = '0; pop = 1'b0;
        repeat (2) step();
        check_quiet("reset");
        check("reset_credit", credit_cnt, 8);
        rst = 1'b0;

        // Timeout rotation: A holds 16 cycles, one bubble, then C.
        req = 4'b0101;
        step();
        check_grant("to_first", 0);
        repeat (15) step();
        check_grant("to_last_cycle", 0);
        step();
        check_quiet("to_switch");
        step();
        check_grant("to_next", 2);
        check("to_credit", credit_cnt, 8);
        req = '0;
        step();
        check_quiet("to_drop_switch");
        step();
        check_quiet("to_idle");

        // Burst-count rotation A,B,C,D,A; pop paired with done keeps credits full.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            check_grant("rr_grant", g % 4);
            for (int d = 0; d < 4; d++) begin
                done = 4'(1 << (g % 4)); pop = 1'b1;
                step();
                done = '0; pop = 1'b0;
                if (d < 3) begin
                    check("rr_burst_hold", start, 32'(1 << (g % 4)));
                    step();
                end else begin
                    check("rr_burst_switch", start, 0);
                end
            end
            step();
        end
        check("rr_credit", credit_cnt, 8);
        req = '0;
        repeat (2) step();

        // Credit exhaustion: B drains all 8 credits, parks in IDLE until a pop.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0010;
        step();
        check_grant("cr_grant1", 1);
        for (int d = 0; d < 8; d++) begin
            done = 4'b0010;
            step();
            done = '0;
            check("cr_credit", credit_cnt, 32'(7 - d));
            if (d == 3) begin
                check("cr_burst_switch", start, 0);
                step();
                check_grant("cr_grant2", 1);
            end else if (d < 7) begin
                step();
            end
        end
        check_quiet("cr_empty_idle");
        repeat (5) step();
        check_quiet("cr_still_idle");
        check("cr_still_zero", credit_cnt, 0);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("cr_pop_credit", credit_cnt, 1);
        check_quiet("cr_pop_no_grant_yet");
        step();
        check_grant("cr_regrant", 1);

        // Pop/done cancellation at 3, saturation at 8, foreign done ignored.
        pop = 1'b1;
        repeat (2) step();
        check("cc_pop_to3", credit_cnt, 3);
        done = 4'b0010;
        step();
        done = '0;
        check("cc_pop_done_at3", credit_cnt, 3);
        repeat (5) step();
        check("cc_pop_to8", credit_cnt, 8);
        step();
        pop = 1'b0;
        check("cc_pop_sat8", credit_cnt, 8);
        done = 4'b1101;
        step();
        done = '0;
        check("cc_foreign_done", credit_cnt, 8);
        check_grant("cc_still_granted", 1);
        req = '0;
        repeat (2) step();

        // Request drop after one done: bubble, then D wins from ptr=3 over A.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1100;
        step();
        check_grant("rd_grant_c", 2);
        done = 4'b0100;
        step();
        done = '0;
        check("rd_credit", credit_cnt, 7);
        req = 4'b1001;
        step();
        check_quiet("rd_switch");
        step();
        check_grant("rd_grant_d", 3);

        // Reset mid-grant at credit 5 aborts, restores credits, resets ptr.
        for (int d = 0; d < 2; d++) begin
            done = 4'b1000;
            step();
            done = '0;
        end
        check("rs_credit5", credit_cnt, 5);
        rst = 1'b1; done = 4'b1000;
        step();
        rst = 1'b0; done = '0;
        check_quiet("rs_abort");
        check("rs_credit", credit_cnt, 8);
        step();
        check_grant("rs_ptr0_grant_a", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
